// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array edge feeder.
package systolic_pkg;

    localparam int DEFAULT_DATA_SIZE = 4;
    localparam int DEFAULT_N         = 4;
    localparam int FEED_CYCLES       = 3 * DEFAULT_N - 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } feeder_state_t;

    // The skewed wavefront needs 2N-1 diagonals plus N-1 cycles of tail padding.
    function automatic int feed_cycles(input int n);
        return 3 * n - 2;
    endfunction

endpackage

// File: rtl/operand_bank.sv
// One N*N operand bank: a single write port and N combinational read ports.
module operand_bank #(
    parameter int DATA_SIZE = 4,
    parameter int N         = 4,
    parameter int AW        = $clog2(N * N)
) (
    input  logic                                clk,
    input  logic                                we_i,
    input  logic [AW-1:0]                       waddr_i,
    input  logic [DATA_SIZE-1:0]                wdata_i,
    input  logic [N-1:0][AW-1:0]                raddr_i,
    output logic [N-1:0][DATA_SIZE-1:0]         rdata_o
);

    localparam logic [AW:0] Depth = (AW + 1)'(N * N);

    logic [DATA_SIZE-1:0] mem_q [N * N];

    // Contents survive reset; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (we_i && ({1'b0, waddr_i} < Depth)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int p = 0; p < N; p++) begin
            rdata_o[p] = mem_q[raddr_i[p]];
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Feeds skewed A rows / B columns into an N x N systolic PE array.
// Define SYSTOLIC_FEEDER_OUT_REG_EN to register a_out, b_out, pe_clear and done.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int N         = DEFAULT_N
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic                          load_sel,
    input  logic [$clog2(N*N)-1:0]        load_addr,
    input  logic [DATA_SIZE-1:0]          load_data,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          pe_clear,
    output logic [N*DATA_SIZE-1:0]        a_out,
    output logic [N*DATA_SIZE-1:0]        b_out
);

    localparam int AW         = $clog2(N * N);
    localparam int FeedCycles = feed_cycles(N);
    localparam int CW         = $clog2(FeedCycles);

    feeder_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0][AW-1:0]        rdAddrA, rdAddrB;
    logic [N-1:0][DATA_SIZE-1:0] rdDataA, rdDataB;
    logic [N-1:0]                laneValid;
    logic [N*DATA_SIZE-1:0]      aRaw, bRaw;
    logic                        clearRaw, doneRaw;
    logic                        weA, weB;

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == CLEAR) || (state_q == FEED) || (state_q == DRAIN);
    assign weA        = load_valid && load_ready && !load_sel;
    assign weB        = load_valid && load_ready && load_sel;

    operand_bank #(.DATA_SIZE(DATA_SIZE), .N(N), .AW(AW)) bankA (
        .clk     (clk),
        .we_i    (weA),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (rdAddrA),
        .rdata_o (rdDataA)
    );

    operand_bank #(.DATA_SIZE(DATA_SIZE), .N(N), .AW(AW)) bankB (
        .clk     (clk),
        .we_i    (weB),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (rdAddrB),
        .rdata_o (rdDataB)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                state_d = FEED;
                cnt_d   = '0;
            end
            FEED: begin
                if (cnt_q == CW'(FeedCycles - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Lane k reads diagonal element t-k; A walks along row k, B down column k.
    always_comb begin
        rdAddrA   = '0;
        rdAddrB   = '0;
        laneValid = '0;
        if (state_q == FEED) begin
            for (int i = 0; i < N; i++) begin
                if ((int'(cnt_q) >= i) && (int'(cnt_q) < i + N)) begin
                    laneValid[i] = 1'b1;
                    rdAddrA[i]   = AW'(i * N + int'(cnt_q) - i);
                    rdAddrB[i]   = AW'((int'(cnt_q) - i) * N + i);
                end
            end
        end
    end

    always_comb begin
        aRaw = '0;
        bRaw = '0;
        for (int i = 0; i < N; i++) begin
            if (laneValid[i]) begin
                aRaw[i*DATA_SIZE +: DATA_SIZE] = rdDataA[i];
                bRaw[i*DATA_SIZE +: DATA_SIZE] = rdDataB[i];
            end
        end
    end

    assign clearRaw = (state_q == CLEAR);
    assign doneRaw  = (state_q == DONE);

`ifdef SYSTOLIC_FEEDER_OUT_REG_EN
    logic [N*DATA_SIZE-1:0] aOut_q, bOut_q;
    logic                   peClear_q, done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            aOut_q    <= '0;
            bOut_q    <= '0;
            peClear_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            aOut_q    <= aRaw;
            bOut_q    <= bRaw;
            peClear_q <= clearRaw;
            done_q    <= doneRaw;
        end
    end

    assign a_out    = aOut_q;
    assign b_out    = bOut_q;
    assign pe_clear = peClear_q;
    assign done     = done_q;
`else
    assign a_out    = aRaw;
    assign b_out    = bRaw;
    assign pe_clear = clearRaw;
    assign done     = doneRaw;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder at N=4, DATA_SIZE=4.
module tb_systolic_feeder;

    localparam int NP = 4;
    localparam int DS = 4;
`ifdef SYSTOLIC_FEEDER_OUT_REG_EN
    localparam int Lag = 1;
`else
    localparam int Lag = 0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            load_valid = 1'b0;
    logic            load_ready;
    logic            load_sel = 1'b0;
    logic [3:0]      load_addr = '0;
    logic [DS-1:0]   load_data = '0;
    logic            start = 1'b0;
    logic            busy;
    logic            done;
    logic            pe_clear;
    logic [NP*DS-1:0] a_out;
    logic [NP*DS-1:0] b_out;

    logic [DS-1:0] modelA [NP*NP];
    logic [DS-1:0] modelB [NP*NP];

    int compareCount = 0;
    int failCount    = 0;

    systolic_feeder #(.DATA_SIZE(DS), .N(NP)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_sel   (load_sel),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pe_clear   (pe_clear),
        .a_out      (a_out),
        .b_out      (b_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected edge vector for cycle k after start-accept (k=2 is feed t=0).
    function automatic logic [NP*DS-1:0] expLanes(input logic selB, input int k);
        logic [NP*DS-1:0] r;
        int t;
        r = '0;
        t = k - 2;
        if (k >= 2 && k <= 3*NP-1) begin
            for (int i = 0; i < NP; i++) begin
                if (t - i >= 0 && t - i < NP) begin
                    r[i*DS +: DS] = selB ? modelB[(t-i)*NP + i] : modelA[i*NP + (t-i)];
                end
            end
        end
        return r;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
        start      = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic sel, input int addr, input logic [DS-1:0] data);
        load_valid = 1'b1;
        load_sel   = sel;
        load_addr  = 4'(addr);
        load_data  = data;
        stepCycle();
        if (sel) modelB[addr] = data;
        else     modelA[addr] = data;
    endtask

    task automatic startPass(input logic withWrite, input int addr, input logic [DS-1:0] data);
        start = 1'b1;
        if (withWrite) begin
            load_valid = 1'b1;
            load_sel   = 1'b0;
            load_addr  = 4'(addr);
            load_data  = data;
        end
        stepCycle();
        if (withWrite) modelA[addr] = data;
    endtask

    task automatic checkCycle(input int k);
        checkOutput($sformatf("busy@%0d", k), busy, (k >= 1 && k <= 4*NP-1));
        checkOutput($sformatf("done@%0d", k), done, (k == 4*NP + Lag));
        checkOutput($sformatf("pe_clear@%0d", k), pe_clear, (k == 1 + Lag));
        checkOutput($sformatf("a_out@%0d", k), a_out, expLanes(1'b0, k - Lag));
        checkOutput($sformatf("b_out@%0d", k), b_out, expLanes(1'b1, k - Lag));
        if (k != 4*NP) checkOutput($sformatf("load_ready@%0d", k), load_ready, (k > 4*NP));
    endtask

    // mode: 0 plain, 1 identity spot checks, 2 busy-time poke, 3 negative-value spot checks
    task automatic runPass(input int mode);
        for (int k = 1; k <= 4*NP + 2; k++) begin
            checkCycle(k);
            if (mode == 1 && k == 2 + Lag) checkOutput("ident_t0_a", a_out, 32'h0001);
            if (mode == 1 && k == 2 + Lag) checkOutput("ident_t0_b", b_out, 32'h0000);
            if (mode == 1 && k == 5 + Lag) checkOutput("ident_t3_b", b_out, 32'hDF13);
            if (mode == 3 && k == 4 + Lag) checkOutput("neg_t2_lane3", a_out[15:12], 32'h0);
            if (mode == 3 && k == 5 + Lag) checkOutput("neg_t3_lane3", a_out[15:12], 32'h8);
            if (mode == 3 && k == 6 + Lag) checkOutput("neg_t4_lane3", a_out[15:12], 32'h0);
            if (mode == 2 && k == 6) begin
                start      = 1'b1;
                load_valid = 1'b1;
                load_sel   = 1'b0;
                load_addr  = 4'd0;
                load_data  = 4'h7;
            end
            @(posedge clk);
            #1;
            start      = 1'b0;
            load_valid = 1'b0;
        end
    endtask

    task automatic runAbort();
        startPass(1'b0, 0, '0);
        for (int k = 1; k <= 6; k++) begin
            checkCycle(k);
            if (k < 6) stepCycle();
        end
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_clear", pe_clear, 0);
        checkOutput("abort_a", a_out, 0);
        checkOutput("abort_b", b_out, 0);
        checkOutput("abort_ready", load_ready, 1);
        for (int k = 0; k < 12; k++) begin
            stepCycle();
            checkOutput($sformatf("abort_nodone@%0d", k), done, 0);
            checkOutput($sformatf("abort_idle@%0d", k), busy, 0);
        end
    endtask

    initial begin
        stepCycle();
        stepCycle();
        reset = 1'b0;
        checkOutput("rst_a_out", a_out, 0);
        checkOutput("rst_b_out", b_out, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pe_clear", pe_clear, 0);
        checkOutput("rst_load_ready", load_ready, 1);

        for (int r = 0; r < NP; r++) begin
            for (int c = 0; c < NP; c++) begin
                applyStimulus(1'b0, r*NP + c, (r == c) ? 4'd1 : 4'd0);
                applyStimulus(1'b1, r*NP + c, 4'(r - c));
            end
        end

        $display("[TB] identity pass");
        startPass(1'b0, 0, '0);
        runPass(1);

        $display("[TB] start/load during busy");
        startPass(1'b0, 0, '0);
        runPass(2);

        $display("[TB] reset abort then replay");
        runAbort();
        startPass(1'b0, 0, '0);
        runPass(1);

        $display("[TB] negative operand written with start");
        startPass(1'b1, 3*NP + 0, 4'b1000);
        runPass(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
